// File: rtl/sdram_cmd_monitor.sv
// SDRAM command-bus monitor: decodes controller commands, models per-bank row/timing state,
// flags protocol errors and pulses rd_valid after CAS latency. Optional statistics: SDRAM_CMD_STATS_EN.
module sdram_cmd_monitor #(
  parameter int ROW_W   = 13,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int T_RAS   = 5,
  parameter int T_RFC   = 7,
  parameter int CAS_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       command,
  input  logic [1:0]       bank,
  input  logic [ROW_W-1:0] addr,
  output logic [3:0]       bank_open,
  output logic [3:0]       bank_busy,
  output logic             refreshing,
  output logic             row_hit,
  output logic             rd_valid,
  output logic             err,
  output logic [2:0]       err_code
`ifdef SDRAM_CMD_STATS_EN
  ,
  output logic [15:0]      act_cnt,
  output logic [15:0]      rw_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam int CW = 8;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_state_e;

  // Per-bank state record; bank_q is the observable FSM state for each bank.
  typedef struct packed {
    bank_state_e      st;
    logic [ROW_W-1:0] row;
    logic [CW-1:0]    trcd;
    logic [CW-1:0]    trp;
    logic [CW-1:0]    tras;
  } bank_t;

  bank_t              bank_q [4];
  bank_t              bank_d [4];
  bank_state_e        eff_st [4];
  logic [CW-1:0]      rfc_q, rfc_d;
  logic [CAS_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [CAS_LAT:0]   rd_pipe_ext;
  logic [3:0]         open_q, open_d, busy_q, busy_d;
  logic               refreshing_q, row_hit_q, err_q;
  logic [2:0]         err_code_q, code_d;
  logic               any_not_idle, pre_all_block, pre_block, refr_now;
  logic               legal, do_act, do_rd, do_wr, do_pre, do_ref;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? v : v - CW'(1);
  endfunction

  // A counter that has already reached 0 means the transition is due this edge,
  // so commands are judged against the state the bank is effectively in.
  always_comb begin
    any_not_idle  = 1'b0;
    pre_all_block = 1'b0;
    for (int b = 0; b < 4; b++) begin
      eff_st[b] = bank_q[b].st;
      if (bank_q[b].st == ST_ACTIVATING && bank_q[b].trcd == '0) eff_st[b] = ST_ACTIVE;
      if (bank_q[b].st == ST_PRECHARGING && bank_q[b].trp == '0) eff_st[b] = ST_IDLE;
      if (eff_st[b] != ST_IDLE) any_not_idle = 1'b1;
      if ((eff_st[b] == ST_ACTIVE || eff_st[b] == ST_ACTIVATING) && bank_q[b].tras != '0)
        pre_all_block = 1'b1;
    end
    refr_now  = (rfc_q != '0);
    pre_block = addr[10] ? pre_all_block : (bank_q[bank].tras != '0);
  end

  always_comb begin
    code_d = 3'd0;
    case (command)
      CMD_ACT:        if (eff_st[bank] != ST_IDLE) code_d = 3'd1;
                      else if (refr_now) code_d = 3'd5;
      CMD_RD, CMD_WR: if (eff_st[bank] != ST_ACTIVE) code_d = 3'd2;
                      else if (refr_now) code_d = 3'd5;
      CMD_PRE:        if (pre_block) code_d = 3'd3;
                      else if (refr_now) code_d = 3'd5;
      CMD_REF:        if (any_not_idle) code_d = 3'd4;
                      else if (refr_now) code_d = 3'd5;
      CMD_LMR:        if (any_not_idle) code_d = 3'd6;
                      else if (refr_now) code_d = 3'd5;
      default:        code_d = 3'd0;
    endcase
    legal  = (code_d == 3'd0);
    do_act = legal && (command == CMD_ACT);
    do_rd  = legal && (command == CMD_RD);
    do_wr  = legal && (command == CMD_WR);
    do_pre = legal && (command == CMD_PRE);
    do_ref = legal && (command == CMD_REF);
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_d[b].st   = eff_st[b];
      bank_d[b].row  = bank_q[b].row;
      bank_d[b].trcd = sat_dec(bank_q[b].trcd);
      bank_d[b].trp  = sat_dec(bank_q[b].trp);
      bank_d[b].tras = sat_dec(bank_q[b].tras);
      if (do_act && bank == 2'(b)) begin
        bank_d[b].st   = ST_ACTIVATING;
        bank_d[b].row  = addr;
        bank_d[b].trcd = CW'(T_RCD - 1);
        bank_d[b].tras = CW'(T_RAS - 1);
      end
      if (do_pre && (addr[10] || bank == 2'(b)) &&
          (eff_st[b] == ST_ACTIVE || eff_st[b] == ST_ACTIVATING)) begin
        bank_d[b].st  = ST_PRECHARGING;
        bank_d[b].trp = CW'(T_RP - 1);
      end
      open_d[b] = (bank_d[b].st == ST_ACTIVE);
      busy_d[b] = (bank_d[b].st == ST_ACTIVATING) || (bank_d[b].st == ST_PRECHARGING);
    end
    if (do_ref) rfc_d = CW'(T_RFC);
    else        rfc_d = sat_dec(rfc_q);
    rd_pipe_ext = {rd_pipe_q, do_rd};
    rd_pipe_d   = rd_pipe_ext[CAS_LAT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) bank_q[b] <= '0;
      rfc_q        <= '0;
      rd_pipe_q    <= '0;
      open_q       <= '0;
      busy_q       <= '0;
      refreshing_q <= 1'b0;
      row_hit_q    <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      for (int b = 0; b < 4; b++) bank_q[b] <= bank_d[b];
      rfc_q        <= rfc_d;
      rd_pipe_q    <= rd_pipe_d;
      open_q       <= open_d;
      busy_q       <= busy_d;
      refreshing_q <= (rfc_d != '0);
      row_hit_q    <= (do_rd || do_wr) && (addr == bank_q[bank].row);
      err_q        <= !legal;
      if (!legal) err_code_q <= code_d;
    end
  end

  assign bank_open  = open_q;
  assign bank_busy  = busy_q;
  assign refreshing = refreshing_q;
  assign row_hit    = row_hit_q;
  assign rd_valid   = rd_pipe_q[CAS_LAT-1];
  assign err        = err_q;
  assign err_code   = err_code_q;

`ifdef SDRAM_CMD_STATS_EN
  logic [15:0] act_cnt_q, rw_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt_q <= '0;
      rw_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (do_act && act_cnt_q != 16'hFFFF) act_cnt_q <= act_cnt_q + 16'd1;
      if ((do_rd || do_wr) && rw_cnt_q != 16'hFFFF) rw_cnt_q <= rw_cnt_q + 16'd1;
      if (!legal && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign act_cnt = act_cnt_q;
  assign rw_cnt  = rw_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Bench for sdram_cmd_monitor: directed scenarios plus random commands, checked against a
// timestamp-based bank model (state derived from cycles elapsed since ACTIVE/PRECHARGE/REFRESH).
module tb_sdram_cmd_monitor;
  localparam int ROW_W   = 13;
  localparam int T_RCD   = 2;
  localparam int T_RP    = 2;
  localparam int T_RAS   = 5;
  localparam int T_RFC   = 7;
  localparam int CAS_LAT = 2;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       command = NOP;
  logic [1:0]       bank = '0;
  logic [ROW_W-1:0] addr = '0;
  logic [3:0]       bank_open, bank_busy;
  logic             refreshing, row_hit, rd_valid, err;
  logic [2:0]       err_code;
`ifdef SDRAM_CMD_STATS_EN
  logic [15:0]      act_cnt, rw_cnt, err_cnt;
`endif

  sdram_cmd_monitor #(
    .ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_RFC(T_RFC), .CAS_LAT(CAS_LAT)
  ) dut (
    .clk(clk), .rst(rst), .command(command), .bank(bank), .addr(addr),
    .bank_open(bank_open), .bank_busy(bank_busy), .refreshing(refreshing),
    .row_hit(row_hit), .rd_valid(rd_valid), .err(err), .err_code(err_code)
`ifdef SDRAM_CMD_STATS_EN
    , .act_cnt(act_cnt), .rw_cnt(rw_cnt), .err_cnt(err_cnt)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bank phase plus the cycle of its last ACTIVE / PRECHARGE
  int          cyc = 0;
  int          phase [4];
  int          act_t [4];
  int          pre_t [4];
  int          ref_t;
  logic [12:0] row_m [4];
  logic [2:0]  last_code;
  bit          rd_sched [0:16383];

  function automatic int st_of(input int b, input int n);
    if (phase[b] == 1) return (n - act_t[b] >= T_RCD) ? 2 : 1;
    if (phase[b] == 2) return (n - pre_t[b] >= T_RP) ? 0 : 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      phase[i] = 0; act_t[i] = -1000; pre_t[i] = -1000; row_m[i] = '0;
    end
    ref_t = -1000;
    last_code = 3'd0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] c, input logic [1:0] b,
                            input logic [12:0] a);
    int n, code, s[4];
    bit refr, blocked, anyb, hit;
    logic [3:0] op, bz;
    n = cyc;
    cyc++;
    if (r) begin
      model_reset();
      for (int i = 0; i < 4; i++) rd_sched[n + i] = 1'b0;
      exp_q.push_back('0);
      return;
    end
    for (int i = 0; i < 4; i++) s[i] = st_of(i, n);
    refr = (n - ref_t >= 1) && (n - ref_t <= T_RFC);
    anyb = (s[0] != 0) || (s[1] != 0) || (s[2] != 0) || (s[3] != 0);
    blocked = 1'b0;
    if (a[10]) begin
      for (int i = 0; i < 4; i++)
        if ((s[i] == 1 || s[i] == 2) && (n - act_t[i] < T_RAS)) blocked = 1'b1;
    end else begin
      blocked = (n - act_t[b] < T_RAS);
    end
    code = 0;
    if (c == ACT)                code = (s[b] != 0) ? 1 : (refr ? 5 : 0);
    else if (c == RD || c == WR) code = (s[b] != 2) ? 2 : (refr ? 5 : 0);
    else if (c == PRE)           code = blocked ? 3 : (refr ? 5 : 0);
    else if (c == REF)           code = anyb ? 4 : (refr ? 5 : 0);
    else if (c == LMR)           code = anyb ? 6 : (refr ? 5 : 0);
    hit = (code == 0) && (c == RD || c == WR) && (a == row_m[b]);
    if (code == 0) begin
      if (c == ACT) begin phase[b] = 1; act_t[b] = n; row_m[b] = a; end
      if (c == RD) rd_sched[n + CAS_LAT - 1] = 1'b1;
      if (c == REF) ref_t = n;
      if (c == PRE)
        for (int i = 0; i < 4; i++)
          if ((a[10] || i == int'(b)) && (s[i] == 1 || s[i] == 2)) begin
            phase[i] = 2; pre_t[i] = n;
          end
    end else begin
      last_code = 3'(code);
    end
    for (int i = 0; i < 4; i++) begin
      op[i] = (st_of(i, n) == 2);
      bz[i] = (st_of(i, n) == 1) || (st_of(i, n) == 3);
    end
    exp_q.push_back({op, bz, (n - ref_t >= 0) && (n - ref_t < T_RFC), hit, rd_sched[n],
                     code != 0, last_code});
  endtask

  // driver: apply one command across one clock edge, then compare mid-cycle
  task automatic step(input logic r, input logic [3:0] c, input logic [1:0] b,
                      input logic [12:0] a);
    logic [14:0] e;
    rst = r; command = c; bank = b; addr = a;
    model_step(r, c, b, a);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("bank_open",  16'(bank_open),  16'(e[14:11]));
    check("bank_busy",  16'(bank_busy),  16'(e[10:7]));
    check("refreshing", 16'(refreshing), 16'(e[6]));
    check("row_hit",    16'(row_hit),    16'(e[5]));
    check("rd_valid",   16'(rd_valid),   16'(e[4]));
    check("err",        16'(err),        16'(e[3]));
    check("err_code",   16'(err_code),   16'(e[2:0]));
  endtask

  task automatic nop(input int k);
    for (int i = 0; i < k; i++) step(1'b0, NOP, 2'd0, 13'd0);
  endtask

  task automatic random_step();
    int r;
    logic [3:0] c;
    logic [12:0] a;
    r = $urandom_range(0, 99);
    if (r < 35)      c = NOP;
    else if (r < 40) c = {1'b1, 3'($urandom_range(0, 7))};
    else if (r < 58) c = ACT;
    else if (r < 70) c = RD;
    else if (r < 78) c = WR;
    else if (r < 88) c = PRE;
    else if (r < 93) c = REF;
    else if (r < 96) c = LMR;
    else             c = NOP;
    a = 13'($urandom_range(0, 3));
    if ($urandom_range(0, 9) < 4) a[10] = 1'b1;
    step($urandom_range(0, 99) == 0, c, 2'($urandom_range(0, 3)), a);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b1, NOP, 2'd0, 13'd0);
    step(1'b1, NOP, 2'd0, 13'd0);
    // open, read after tRCD, row hit, CAS-latency read pulse
    step(1'b0, ACT, 2'd0, 13'h123);
    nop(1);
    step(1'b0, RD, 2'd0, 13'h123);
    nop(4);
    // read before tRCD elapsed
    step(1'b0, ACT, 2'd1, 13'h010);
    step(1'b0, RD, 2'd1, 13'h010);
    nop(3);
    // precharge too early, then at the tRAS boundary
    step(1'b0, ACT, 2'd2, 13'h055);
    nop(2);
    step(1'b0, PRE, 2'd2, 13'h000);
    nop(1);
    step(1'b0, PRE, 2'd2, 13'h000);
    nop(3);
    // refresh window and commands inside/after it
    step(1'b0, PRE, 2'd0, 13'h400);
    nop(3);
    step(1'b0, REF, 2'd0, 13'h000);
    step(1'b0, ACT, 2'd0, 13'h001);
    nop(6);
    step(1'b0, ACT, 2'd0, 13'h001);
    nop(1);
    // two open banks, all-bank precharge, then refresh
    step(1'b0, ACT, 2'd3, 13'h002);
    nop(5);
    step(1'b0, PRE, 2'd1, 13'h400);
    nop(2);
    step(1'b0, REF, 2'd0, 13'h000);
    step(1'b0, LMR, 2'd0, 13'h000);
    nop(7);
    step(1'b0, LMR, 2'd0, 13'h000);
    // reset right after a read, and during precharge
    step(1'b0, ACT, 2'd1, 13'h003);
    nop(2);
    step(1'b0, RD, 2'd1, 13'h003);
    step(1'b1, NOP, 2'd0, 13'd0);
    nop(2);
    step(1'b0, ACT, 2'd2, 13'h004);
    nop(5);
    step(1'b0, PRE, 2'd2, 13'h000);
    step(1'b1, NOP, 2'd0, 13'd0);
    nop(2);
    for (int i = 0; i < 3000; i++) random_step();
    nop(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_monitor.md
Name: sdram_cmd_monitor

Overview:
- Device-side responder for the SDRAM command sequence generators: decodes the 4-bit command bus the controller drives and models per-bank state.
- Tracks per-bank row/timing state (IDLE, ACTIVATING, ACTIVE, PRECHARGING) and refresh.
- Flags protocol and timing violations, and pulses read-data-valid after CAS latency.
- Used as the in-design bus checker and as the bench-side responder for every scg_* sequence.

Parameters:
- ROW_W, 13, row address width.
- T_RCD, 2, cycles from ACTIVE until READ/WRITE is legal on that bank.
- T_RP, 2, cycles from PRECHARGE until the bank is IDLE.
- T_RAS, 5, minimum cycles from ACTIVE to PRECHARGE on the same bank.
- T_RFC, 7, cycles AUTO_REFRESH occupies the device.
- CAS_LAT, 2, cycles from READ command to rd_valid pulse (legal range 1-3).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- command  in  4  {cs_n,ras_n,cas_n,we_n}: 1xxx DESELECT, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE
- bank  in  2  target bank
- addr  in  ROW_W  row for ACTIVE; addr[10]=1 on PRECHARGE selects all banks
- bank_open  out  4  bank in ACTIVE state (tRCD elapsed)
- bank_busy  out  4  bank in ACTIVATING or PRECHARGING
- refreshing  out  1  high while T_RFC counter runs
- row_hit  out  1  registered; 1 the cycle after a legal READ/WRITE whose addr equals the stored row
- rd_valid  out  1  one-cycle pulse CAS_LAT cycles after a legal READ
- err  out  1  one-cycle pulse the cycle after an illegal command
- err_code  out  3  valid with err; holds its last value otherwise

Behaviour:
- Reset (rst high at a clk edge): all banks IDLE; all counters 0; all outputs 0 (err_code 0). Any in-flight read pipeline, refresh or timing counter is cleared immediately, mid-operation included.
- Commands are sampled every rising edge. DESELECT and NOP are no-ops.
- Per-bank FSM:
  - IDLE -ACTIVE-> ACTIVATING: row latched; tRCD counter = T_RCD-1; tRAS counter = T_RAS-1.
  - ACTIVATING -> ACTIVE when the tRCD counter reaches 0.
  - ACTIVE/ACTIVATING -PRECHARGE-> PRECHARGING: tRP counter = T_RP-1.
  - PRECHARGING -> IDLE when the tRP counter reaches 0.
  - The tRAS counter decrements independently of state and saturates at 0.
- ACTIVE to a non-IDLE bank: err, code 1.
- READ/WRITE to a bank not ACTIVE: err, code 2.
- PRECHARGE:
  - tRAS counter nonzero: err, code 3.
  - To an IDLE or PRECHARGING bank: legal no-op.
  - All-bank PRECHARGE: applied only if every ACTIVE/ACTIVATING bank passes tRAS; otherwise code 3 and no bank changes.
- AUTO_REFRESH:
  - Any bank not IDLE: err, code 4.
  - Otherwise refreshing=1 for T_RFC cycles starting the next cycle.
- Any non-NOP/DESELECT command while refreshing: err, code 5.
- LOAD_MODE with any bank not IDLE: err, code 6.
- Illegal commands cause no state change. Error checks take priority; the code is the first matching rule above.
- READ pipeline: CAS_LAT-deep shift register. Back-to-back READs each produce their own pulse.
- Bank status outputs:
  - bank_open and bank_busy are registered state decodes. They reflect the command one cycle after its edge.
  - A bank is never simultaneously open and busy.

Optional Feature:
- Macro: SDRAM_CMD_STATS_EN.
- Defined: adds output ports act_cnt[15:0], rw_cnt[15:0], err_cnt[15:0]. These are saturating counters of legal ACTIVEs, legal READ/WRITEs, and err pulses; they reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ACTIVE bank0 row 0x123, NOPs, READ bank0 addr 0x123 at cycle +2 -> bank_open[0]=1 from cycle +2; no err; row_hit=1 next cycle; rd_valid exactly 2 cycles after READ.
- ACTIVE bank1, READ bank1 one cycle later -> err=1, err_code=2; no rd_valid.
- ACTIVE bank2, PRECHARGE bank2 after 3 cycles -> err_code=3, bank stays open. PRECHARGE at cycle 5 -> bank_busy[2] for 2 cycles, then IDLE.
- All banks IDLE, AUTO_REFRESH -> refreshing high 7 cycles. ACTIVE during refresh -> err_code=5. ACTIVE after refresh -> legal.
- Banks 0 and 3 open, PRECHARGE with addr[10]=1 after tRAS -> both PRECHARGING, then IDLE after 2 cycles; AUTO_REFRESH then legal.
- rst asserted 1 cycle after a READ and during PRECHARGING -> no rd_valid; all outputs 0 the cycle after rst.
